// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold, flush bubbles and a saturating bubble counter.
// Optional write-back capture during stall is enabled by defining ID_EX_STALL_CAPTURE_EN.
module id_ex_reg #(
    parameter int unsigned DATA_WID     = 16,
    parameter int unsigned REG_ADDR_WID = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    id_valid,
    input  logic [2:0]              id_alu_src,
    input  logic [3:0]              id_alu_op,
    input  logic [DATA_WID-1:0]     id_read_data_a,
    input  logic [DATA_WID-1:0]     id_read_data_b,
    input  logic [DATA_WID-1:0]     id_immediate,
    input  logic [REG_ADDR_WID-1:0] id_rx,
    input  logic [REG_ADDR_WID-1:0] id_ry,
    input  logic                    id_reg_write,
    input  logic                    id_mem_read,
    input  logic                    id_mem_write,
    input  logic [REG_ADDR_WID-1:0] id_wb_dst,
    input  logic                    wb_we,
    input  logic [REG_ADDR_WID-1:0] wb_addr,
    input  logic [DATA_WID-1:0]     wb_data,
    output logic                    ex_valid,
    output logic [2:0]              ex_alu_src,
    output logic [3:0]              ex_alu_op,
    output logic [DATA_WID-1:0]     ex_read_data_a,
    output logic [DATA_WID-1:0]     ex_read_data_b,
    output logic [DATA_WID-1:0]     ex_immediate,
    output logic [REG_ADDR_WID-1:0] ex_rx,
    output logic [REG_ADDR_WID-1:0] ex_ry,
    output logic                    ex_reg_write,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write,
    output logic [REG_ADDR_WID-1:0] ex_wb_dst,
    output logic [7:0]              bubble_count
);

    localparam logic [2:0] SRC_NULL = 3'b000;

    logic                    valid_d;
    logic [2:0]              alu_src_d;
    logic [3:0]              alu_op_d;
    logic [DATA_WID-1:0]     data_a_d;
    logic [DATA_WID-1:0]     data_b_d;
    logic [DATA_WID-1:0]     imm_d;
    logic [REG_ADDR_WID-1:0] rx_d;
    logic [REG_ADDR_WID-1:0] ry_d;
    logic                    reg_write_d;
    logic                    mem_read_d;
    logic                    mem_write_d;
    logic [REG_ADDR_WID-1:0] wb_dst_d;
    logic [7:0]              bubble_count_d;
    logic                    bubble_load;

`ifndef ID_EX_STALL_CAPTURE_EN
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

    always_comb begin
        valid_d     = ex_valid;
        alu_src_d   = ex_alu_src;
        alu_op_d    = ex_alu_op;
        data_a_d    = ex_read_data_a;
        data_b_d    = ex_read_data_b;
        imm_d       = ex_immediate;
        rx_d        = ex_rx;
        ry_d        = ex_ry;
        reg_write_d = ex_reg_write;
        mem_read_d  = ex_mem_read;
        mem_write_d = ex_mem_write;
        wb_dst_d    = ex_wb_dst;
        bubble_load = 1'b0;

        if (flush) begin
            valid_d     = 1'b0;
            alu_src_d   = SRC_NULL;
            alu_op_d    = '0;
            data_a_d    = '0;
            data_b_d    = '0;
            imm_d       = '0;
            rx_d        = '0;
            ry_d        = '0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            wb_dst_d    = '0;
            bubble_load = 1'b1;
        end else if (stall) begin
`ifdef ID_EX_STALL_CAPTURE_EN
            // Forward a write-back that lands on a held source register.
            if (ex_valid && wb_we && (wb_addr == ex_rx)) data_a_d = wb_data;
            if (ex_valid && wb_we && (wb_addr == ex_ry)) data_b_d = wb_data;
`endif
        end else begin
            valid_d     = id_valid;
            alu_src_d   = id_alu_src;
            alu_op_d    = id_alu_op;
            data_a_d    = id_read_data_a;
            data_b_d    = id_read_data_b;
            imm_d       = id_immediate;
            rx_d        = id_rx;
            ry_d        = id_ry;
            wb_dst_d    = id_wb_dst;
            reg_write_d = id_valid & id_reg_write;
            mem_read_d  = id_valid & id_mem_read;
            mem_write_d = id_valid & id_mem_write;
            bubble_load = ~id_valid;
        end

        bubble_count_d = bubble_count;
        if (bubble_load && (bubble_count != 8'hFF)) bubble_count_d = bubble_count + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid       <= 1'b0;
            ex_alu_src     <= SRC_NULL;
            ex_alu_op      <= '0;
            ex_read_data_a <= '0;
            ex_read_data_b <= '0;
            ex_immediate   <= '0;
            ex_rx          <= '0;
            ex_ry          <= '0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_wb_dst      <= '0;
            bubble_count   <= 8'd0;
        end else begin
            ex_valid       <= valid_d;
            ex_alu_src     <= alu_src_d;
            ex_alu_op      <= alu_op_d;
            ex_read_data_a <= data_a_d;
            ex_read_data_b <= data_b_d;
            ex_immediate   <= imm_d;
            ex_rx          <= rx_d;
            ex_ry          <= ry_d;
            ex_reg_write   <= reg_write_d;
            ex_mem_read    <= mem_read_d;
            ex_mem_write   <= mem_write_d;
            ex_wb_dst      <= wb_dst_d;
            bubble_count   <= bubble_count_d;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed vector table, hand sequences, and a
// randomized run compared against a behavioural pipeline-register model.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [2:0]  id_alu_src;
    logic [3:0]  id_alu_op;
    logic [15:0] id_read_data_a, id_read_data_b, id_immediate;
    logic [3:0]  id_rx, id_ry;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic [3:0]  id_wb_dst;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ex_valid;
    logic [2:0]  ex_alu_src;
    logic [3:0]  ex_alu_op;
    logic [15:0] ex_read_data_a, ex_read_data_b, ex_immediate;
    logic [3:0]  ex_rx, ex_ry;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [3:0]  ex_wb_dst;
    logic [7:0]  bubble_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_read_data_a(id_read_data_a), .id_read_data_b(id_read_data_b),
        .id_immediate(id_immediate), .id_rx(id_rx), .id_ry(id_ry),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_wb_dst(id_wb_dst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_read_data_a(ex_read_data_a), .ex_read_data_b(ex_read_data_b),
        .ex_immediate(ex_immediate), .ex_rx(ex_rx), .ex_ry(ex_ry),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_wb_dst(ex_wb_dst),
        .bubble_count(bubble_count)
    );

    typedef struct packed {
        logic        valid;
        logic [2:0]  alu_src;
        logic [3:0]  alu_op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [3:0]  rx;
        logic [3:0]  ry;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [3:0]  dst;
        logic [7:0]  cnt;
    } ex_t;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        valid;
        logic [2:0]  src;
        logic [15:0] a;
        logic [15:0] imm;
        logic        rw;
        logic        e_valid;
        logic [2:0]  e_src;
        logic [15:0] e_a;
        logic [15:0] e_imm;
        logic        e_rw;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tbl [11];
    ex_t  model;

    function automatic ex_t dut_state();
        ex_t s;
        s = '{ex_valid, ex_alu_src, ex_alu_op, ex_read_data_a, ex_read_data_b, ex_immediate,
              ex_rx, ex_ry, ex_reg_write, ex_mem_read, ex_mem_write, ex_wb_dst, bubble_count};
        return s;
    endfunction

    // Reference: what the execute stage should see after an edge with the current inputs.
    task automatic model_edge();
        ex_t n;
        n = model;
        if (!rst) begin
            n = '0;
        end else if (flush) begin
            n = '0;
            n.cnt = (model.cnt == 8'd255) ? 8'd255 : model.cnt + 8'd1;
        end else if (stall) begin
`ifdef ID_EX_STALL_CAPTURE_EN
            if (model.valid && wb_we && wb_addr == model.rx) n.a = wb_data;
            if (model.valid && wb_we && wb_addr == model.ry) n.b = wb_data;
`endif
        end else begin
            n = '{id_valid, id_alu_src, id_alu_op, id_read_data_a, id_read_data_b, id_immediate,
                  id_rx, id_ry, id_reg_write, id_mem_read, id_mem_write, id_wb_dst, model.cnt};
            if (!id_valid) begin
                n.rw = 1'b0;
                n.mr = 1'b0;
                n.mw = 1'b0;
                n.cnt = (model.cnt == 8'd255) ? 8'd255 : model.cnt + 8'd1;
            end
        end
        model = n;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string name);
        ex_t s;
        s = dut_state();
        checks++;
        if (s !== model) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, s, model, $time);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_alu_src = 3'b000; id_alu_op = 4'h0;
        id_read_data_a = 16'h0; id_read_data_b = 16'h0; id_immediate = 16'h0;
        id_rx = 4'h0; id_ry = 4'h0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_wb_dst = 4'h0;
        wb_we = 1'b0; wb_addr = 4'h0; wb_data = 16'h0;
    endtask

    initial begin
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        model = '0;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 16'h0000, 16'h0000, 1'b0,
                    1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 8'd0};
        tbl[1]  = tbl[0];
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 16'h1234, 16'h00FF, 1'b0,
                    1'b1, 3'b010, 16'h1234, 16'h00FF, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 16'h0AAA, 16'h0000, 1'b1,
                    1'b1, 3'b001, 16'h0AAA, 16'h0000, 1'b1, 8'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 16'h5555, 16'h7777, 1'b0,
                    1'b1, 3'b001, 16'h0AAA, 16'h0000, 1'b1, 8'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 16'h6666, 16'h8888, 1'b0,
                    1'b1, 3'b001, 16'h0AAA, 16'h0000, 1'b1, 8'd0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 16'h9999, 16'hAAAA, 1'b1,
                    1'b1, 3'b001, 16'h0AAA, 16'h0000, 1'b1, 8'd0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b011, 16'h4444, 16'h5555, 1'b1,
                    1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 8'd1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 16'h2222, 16'h3333, 1'b1,
                    1'b0, 3'b101, 16'h2222, 16'h3333, 1'b0, 8'd2};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 16'h0001, 16'h0002, 1'b1,
                    1'b0, 3'b000, 16'h0000, 16'h0000, 1'b0, 8'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 16'h0001, 16'h0002, 1'b1,
                    1'b1, 3'b010, 16'h0001, 16'h0002, 1'b1, 8'd0};

        idle_inputs();
        #2;
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; stall = tbl[i].stall; flush = tbl[i].flush;
            id_valid = tbl[i].valid; id_alu_src = tbl[i].src;
            id_read_data_a = tbl[i].a; id_immediate = tbl[i].imm; id_reg_write = tbl[i].rw;
            cycle();
            chk($sformatf("vec%0d valid", i), 32'(ex_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d alu_src", i), 32'(ex_alu_src), 32'(tbl[i].e_src));
            chk($sformatf("vec%0d data_a", i), 32'(ex_read_data_a), 32'(tbl[i].e_a));
            chk($sformatf("vec%0d imm", i), 32'(ex_immediate), 32'(tbl[i].e_imm));
            chk($sformatf("vec%0d reg_write", i), 32'(ex_reg_write), 32'(tbl[i].e_rw));
            chk($sformatf("vec%0d bubble_count", i), 32'(bubble_count), 32'(tbl[i].e_cnt));
        end

        // Stall-time capture: matching, mismatching address, and invalid held instruction.
        idle_inputs();
        id_valid = 1'b1; id_rx = 4'h3; id_ry = 4'h3;
        id_read_data_a = 16'h1111; id_read_data_b = 16'h2222;
        cycle();
        stall = 1'b1; id_read_data_a = 16'h7070; id_read_data_b = 16'h0707;
        wb_we = 1'b1; wb_addr = 4'h3; wb_data = 16'hBEEF;
        cycle();
`ifdef ID_EX_STALL_CAPTURE_EN
        exp_a = 16'hBEEF; exp_b = 16'hBEEF;
`else
        exp_a = 16'h1111; exp_b = 16'h2222;
`endif
        chk("capture a", 32'(ex_read_data_a), 32'(exp_a));
        chk("capture b", 32'(ex_read_data_b), 32'(exp_b));
        wb_addr = 4'h4; wb_data = 16'hDEAD;
        cycle();
        chk("capture addr miss a", 32'(ex_read_data_a), 32'(exp_a));
        chk("capture addr miss b", 32'(ex_read_data_b), 32'(exp_b));
        wb_we = 1'b0; wb_addr = 4'h3;
        cycle();
        chk("capture we off a", 32'(ex_read_data_a), 32'(exp_a));
        stall = 1'b0; wb_we = 1'b0; id_valid = 1'b0;
        id_read_data_a = 16'h4321; id_read_data_b = 16'h8765;
        cycle();
        stall = 1'b1; wb_we = 1'b1; wb_data = 16'hCAFE;
        cycle();
        chk("capture invalid a", 32'(ex_read_data_a), 32'h4321);
        chk("capture invalid b", 32'(ex_read_data_b), 32'h8765);

        // Bubble counter saturation.
        idle_inputs();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            cycle();
            if (i == 254) chk("count 254", 32'(bubble_count), 32'd254);
            if (i == 255) chk("count 255", 32'(bubble_count), 32'd255);
        end
        chk("count saturated", 32'(bubble_count), 32'd255);
        chk_model("model after saturation");

        // Randomized run against the model, beginning from reset.
        idle_inputs();
        rst = 1'b0;
        cycle();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) >= 3);
            stall = ($urandom_range(0, 99) < 30);
            flush = ($urandom_range(0, 99) < 10);
            id_valid = ($urandom_range(0, 99) < 70);
            id_alu_src = 3'($urandom_range(0, 5));
            id_alu_op = 4'($urandom);
            id_read_data_a = 16'($urandom);
            id_read_data_b = 16'($urandom);
            id_immediate = 16'($urandom);
            id_rx = 4'($urandom_range(0, 3));
            id_ry = 4'($urandom_range(0, 3));
            id_reg_write = 1'($urandom);
            id_mem_read = 1'($urandom);
            id_mem_write = 1'($urandom);
            id_wb_dst = 4'($urandom);
            wb_we = 1'($urandom);
            wb_addr = 4'($urandom_range(0, 4));
            wb_data = 16'($urandom);
            cycle();
            chk_model($sformatf("random cycle %0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
